// File: rtl/pipelined_controller_if.sv
// -----------------------------------------------------------------------------
// pipelined_controller_if
// Bus between the pipeline datapath and its control unit.
//   Datapath -> controller : opCode, func, equalD, flushE
//   Controller -> datapath : D-stage  pcSrcD, jumpD, branchD, clearD, illegalD
//                            E-stage  regWriteE, memtoRegE, memWriteE, aluSrcE,
//                                     regDestE, aluControlE
//                            M-stage  regWriteM, memtoRegM, memWriteM
//                            W-stage  regWriteW, memtoRegW
// Modports: master = datapath / bench side, slave = controller side.
// There is no valid/ready handshake: every signal is sampled on every cycle.
// -----------------------------------------------------------------------------
interface pipelined_controller_if #(
  parameter int ALU_CTRL_W = 3,
  parameter int OPC_W      = 6
);
  logic [OPC_W-1:0]      opCode;
  logic [OPC_W-1:0]      func;
  logic                  equalD;
  logic                  flushE;

  logic                  pcSrcD;
  logic                  jumpD;
  logic                  branchD;
  logic                  clearD;
  logic                  illegalD;

  logic                  regWriteE;
  logic                  memtoRegE;
  logic                  memWriteE;
  logic                  aluSrcE;
  logic                  regDestE;
  logic [ALU_CTRL_W-1:0] aluControlE;

  logic                  regWriteM;
  logic                  memtoRegM;
  logic                  memWriteM;

  logic                  regWriteW;
  logic                  memtoRegW;

  modport master (
    output opCode, func, equalD, flushE,
    input  pcSrcD, jumpD, branchD, clearD, illegalD,
    input  regWriteE, memtoRegE, memWriteE, aluSrcE, regDestE, aluControlE,
    input  regWriteM, memtoRegM, memWriteM,
    input  regWriteW, memtoRegW
  );

  modport slave (
    input  opCode, func, equalD, flushE,
    output pcSrcD, jumpD, branchD, clearD, illegalD,
    output regWriteE, memtoRegE, memWriteE, aluSrcE, regDestE, aluControlE,
    output regWriteM, memtoRegM, memWriteM,
    output regWriteW, memtoRegW
  );
endinterface

// File: rtl/pipelined_controller.sv
// -----------------------------------------------------------------------------
// pipelined_controller
// Control unit for a 5-stage MIPS-style pipeline. Decodes opCode/func in D
// (combinational), then carries the control bundle through E, M and W
// registers. Illegal encodings decode to an all-zero bundle with illegalD=1.
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous active-high reset, clears E/M/W registers
//   bus  - pipelined_controller_if.slave (decode inputs, stage controls)
// Optional feature: define CTRL_BNE_EN to decode opcode 000101 as bne.
// -----------------------------------------------------------------------------
module pipelined_controller #(
  parameter int ALU_CTRL_W = 3,
  parameter int OPC_W      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  pipelined_controller_if.slave     bus
);

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
`ifdef CTRL_BNE_EN
  localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'b000101);
`endif

  localparam logic [OPC_W-1:0] FN_ADD = OPC_W'(6'b100000);
  localparam logic [OPC_W-1:0] FN_SUB = OPC_W'(6'b100010);
  localparam logic [OPC_W-1:0] FN_AND = OPC_W'(6'b100100);
  localparam logic [OPC_W-1:0] FN_OR  = OPC_W'(6'b100101);
  localparam logic [OPC_W-1:0] FN_SLT = OPC_W'(6'b101010);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_dest;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } e_bundle_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } m_bundle_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } w_bundle_t;

  e_bundle_t dec_d;
  logic [2:0] alu3_d;
  logic       branch_d;
  logic       jump_d;
  logic       illegal_d;
  logic       branch_on_ne_d;
  logic       pc_src_d;

  e_bundle_t e_d, e_q;
  m_bundle_t m_d, m_q;
  w_bundle_t w_d, w_q;

  // Decode. Defaults are the all-zero bundle, so any illegal path only has to
  // raise illegal_d and leave everything else untouched.
  always_comb begin
    dec_d          = '0;
    alu3_d         = 3'b000;
    branch_d       = 1'b0;
    jump_d         = 1'b0;
    illegal_d      = 1'b0;
    branch_on_ne_d = 1'b0;
    case (bus.opCode)
      OP_RTYPE: begin
        case (bus.func)
          FN_ADD:  alu3_d = ALU_ADD;
          FN_SUB:  alu3_d = ALU_SUB;
          FN_AND:  alu3_d = ALU_AND;
          FN_OR:   alu3_d = ALU_OR;
          FN_SLT:  alu3_d = ALU_SLT;
          default: illegal_d = 1'b1;
        endcase
        if (!illegal_d) begin
          dec_d.reg_write = 1'b1;
          dec_d.reg_dest  = 1'b1;
        end
      end
      OP_LW: begin
        dec_d.reg_write  = 1'b1;
        dec_d.alu_src    = 1'b1;
        dec_d.mem_to_reg = 1'b1;
        alu3_d           = ALU_ADD;
      end
      OP_SW: begin
        dec_d.mem_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        alu3_d          = ALU_ADD;
      end
      OP_BEQ: begin
        branch_d = 1'b1;
        alu3_d   = ALU_SUB;
      end
`ifdef CTRL_BNE_EN
      OP_BNE: begin
        branch_d       = 1'b1;
        branch_on_ne_d = 1'b1;
        alu3_d         = ALU_SUB;
      end
`endif
      OP_ADDI: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        alu3_d          = ALU_ADD;
      end
      OP_J: begin
        jump_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    // ALU code lives in the low three bits; wider fields are zero-extended.
    dec_d.alu_ctrl = ALU_CTRL_W'(alu3_d);
  end

  // Branch resolves in D so the fetch redirect needs no register delay.
  assign pc_src_d = branch_d & (branch_on_ne_d ? ~bus.equalD : bus.equalD);

  assign bus.pcSrcD   = pc_src_d;
  assign bus.jumpD    = jump_d;
  assign bus.branchD  = branch_d;
  assign bus.clearD   = pc_src_d | jump_d;
  assign bus.illegalD = illegal_d;

  // A flush replaces the decoded bundle with a bubble; downstream stages
  // keep advancing so older instructions still retire.
  assign e_d = bus.flushE ? '0 : dec_d;
  assign m_d = '{reg_write: e_q.reg_write, mem_to_reg: e_q.mem_to_reg,
                 mem_write: e_q.mem_write};
  assign w_d = '{reg_write: m_q.reg_write, mem_to_reg: m_q.mem_to_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign bus.regWriteE   = e_q.reg_write;
  assign bus.memtoRegE   = e_q.mem_to_reg;
  assign bus.memWriteE   = e_q.mem_write;
  assign bus.aluSrcE     = e_q.alu_src;
  assign bus.regDestE    = e_q.reg_dest;
  assign bus.aluControlE = e_q.alu_ctrl;

  assign bus.regWriteM = m_q.reg_write;
  assign bus.memtoRegM = m_q.mem_to_reg;
  assign bus.memWriteM = m_q.mem_write;

  assign bus.regWriteW = w_q.reg_write;
  assign bus.memtoRegW = w_q.mem_to_reg;

endmodule

// File: tb/tb_pipelined_controller.sv
// -----------------------------------------------------------------------------
// tb_pipelined_controller
// Directed bench for pipelined_controller. Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 time unit after the edge that updates
// them (or 1 time unit after an input change for D-stage outputs).
// Build with +define+CTRL_BNE_EN to exercise the bne decode.
// -----------------------------------------------------------------------------
module tb_pipelined_controller;

  localparam int ALU_W = 3;
  localparam int OPC_W = 6;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  pipelined_controller_if #(.ALU_CTRL_W(ALU_W), .OPC_W(OPC_W)) bus ();

  pipelined_controller #(.ALU_CTRL_W(ALU_W), .OPC_W(OPC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic eq, input logic fl);
    bus.opCode = op;
    bus.func   = fn;
    bus.equalD = eq;
    bus.flushE = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed views: E = {rw, m2r, mw, asrc, rdest, alu}; D = {pcsrc, jump,
  // branch, clear, illegal}; M = {rw, m2r, mw}; W = {rw, m2r}.
  function automatic logic [7:0] e_vec();
    return {bus.regWriteE, bus.memtoRegE, bus.memWriteE, bus.aluSrcE,
            bus.regDestE, bus.aluControlE};
  endfunction

  function automatic logic [4:0] d_vec();
    return {bus.pcSrcD, bus.jumpD, bus.branchD, bus.clearD, bus.illegalD};
  endfunction

  function automatic logic [2:0] m_vec();
    return {bus.regWriteM, bus.memtoRegM, bus.memWriteM};
  endfunction

  function automatic logic [1:0] w_vec();
    return {bus.regWriteW, bus.memtoRegW};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] e_got;
    // Reset and flush together, with an illegal opcode on the D inputs.
    rst = 1'b1;
    drive(OP_BAD, 6'd0, 1'b0, 1'b1);
    tick();
    e_got = e_vec();
    tests_run++;
    if ({e_got, m_vec(), w_vec()} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: got %h expected %h", {e_got, m_vec(), w_vec()}, 13'd0);
    end
    // D outputs stay live during reset.
    tests_run++;
    if (d_vec() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL reset_d_live: got %b expected %b", d_vec(), 5'b00001);
    end
    // lw on the inputs with reset still high must not load E.
    drive(OP_LW, 6'd0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (e_vec() !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_holds_e: got %h expected %h", e_vec(), 8'h00);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    drive(OP_LW, 6'd0, 1'b0, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b00000) begin
      tests_failed++;
      $display("FAIL lw_d: got %b expected %b", d_vec(), 5'b00000);
    end
    tick();
    tests_run++;
    if (e_vec() !== {5'b11010, 3'b010}) begin
      tests_failed++;
      $display("FAIL lw_e: got %h expected %h", e_vec(), {5'b11010, 3'b010});
    end
    drive(OP_BAD, 6'd0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({e_vec(), m_vec()} !== {8'h00, 3'b110}) begin
      tests_failed++;
      $display("FAIL lw_m: got %h expected %h", {e_vec(), m_vec()}, {8'h00, 3'b110});
    end
    tick();
    tests_run++;
    if ({m_vec(), w_vec()} !== {3'b000, 2'b11}) begin
      tests_failed++;
      $display("FAIL lw_w: got %b expected %b", {m_vec(), w_vec()}, 5'b00011);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn_tab  [5] = '{6'b100010, 6'b101010, 6'b100000, 6'b100100, 6'b100101};
    logic [2:0] alu_tab [5] = '{3'b110,    3'b111,    3'b010,    3'b000,    3'b001};
    for (int i = 0; i < 5; i++) begin
      drive(OP_R, fn_tab[i], 1'b0, 1'b0);
      tick();
      tests_run++;
      if (e_vec() !== {5'b10001, alu_tab[i]}) begin
        tests_failed++;
        $display("FAIL rtype_e[%0d]: got %h expected %h", i, e_vec(), {5'b10001, alu_tab[i]});
      end
    end
    // Unlisted func is illegal and bubbles.
    drive(OP_R, 6'b000000, 1'b1, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL rtype_bad_d: got %b expected %b", d_vec(), 5'b00001);
    end
    tick();
    tests_run++;
    if (e_vec() !== 8'h00) begin
      tests_failed++;
      $display("FAIL rtype_bad_e: got %h expected %h", e_vec(), 8'h00);
    end
  endtask

  task automatic test_branch();
    drive(OP_BEQ, 6'd0, 1'b1, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b10110) begin
      tests_failed++;
      $display("FAIL beq_taken_d: got %b expected %b", d_vec(), 5'b10110);
    end
    drive(OP_BEQ, 6'd0, 1'b0, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b00100) begin
      tests_failed++;
      $display("FAIL beq_not_taken_d: got %b expected %b", d_vec(), 5'b00100);
    end
    tick();
    tests_run++;
    if (e_vec() !== {5'b00000, 3'b110}) begin
      tests_failed++;
      $display("FAIL beq_e: got %h expected %h", e_vec(), {5'b00000, 3'b110});
    end
    drive(OP_J, 6'd0, 1'b0, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b01010) begin
      tests_failed++;
      $display("FAIL j_d: got %b expected %b", d_vec(), 5'b01010);
    end
    tick();
    tests_run++;
    if (e_vec() !== 8'h00) begin
      tests_failed++;
      $display("FAIL j_e: got %h expected %h", e_vec(), 8'h00);
    end
  endtask

  task automatic test_flush();
    // Flushed sw never reaches memory.
    drive(OP_SW, 6'd0, 1'b0, 1'b1);
    tick();
    tests_run++;
    if (e_vec() !== 8'h00) begin
      tests_failed++;
      $display("FAIL flush_e: got %h expected %h", e_vec(), 8'h00);
    end
    drive(OP_BAD, 6'd0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (bus.memWriteM !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_m: got %b expected %b", bus.memWriteM, 1'b0);
    end
    // Unflushed sw, followed by a flush that must not disturb M.
    drive(OP_SW, 6'd0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (e_vec() !== {5'b00110, 3'b010}) begin
      tests_failed++;
      $display("FAIL sw_e: got %h expected %h", e_vec(), {5'b00110, 3'b010});
    end
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    tick();
    tests_run++;
    if ({e_vec(), m_vec()} !== {8'h00, 3'b001}) begin
      tests_failed++;
      $display("FAIL sw_m: got %h expected %h", {e_vec(), m_vec()}, {8'h00, 3'b001});
    end
    drive(OP_BAD, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    drive(OP_BAD, 6'd0, 1'b1, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL illegal_d: got %b expected %b", d_vec(), 5'b00001);
    end
    tick();
    tests_run++;
    if (e_vec() !== 8'h00) begin
      tests_failed++;
      $display("FAIL illegal_e: got %h expected %h", e_vec(), 8'h00);
    end
`ifdef CTRL_BNE_EN
    drive(OP_BNE, 6'd0, 1'b0, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b10110) begin
      tests_failed++;
      $display("FAIL bne_taken_d: got %b expected %b", d_vec(), 5'b10110);
    end
    tick();
    tests_run++;
    if (e_vec() !== {5'b00000, 3'b110}) begin
      tests_failed++;
      $display("FAIL bne_e: got %h expected %h", e_vec(), {5'b00000, 3'b110});
    end
    drive(OP_BNE, 6'd0, 1'b1, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b00100) begin
      tests_failed++;
      $display("FAIL bne_not_taken_d: got %b expected %b", d_vec(), 5'b00100);
    end
`else
    drive(OP_BNE, 6'd0, 1'b0, 1'b0);
    tests_run++;
    if (d_vec() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL bne_off_d: got %b expected %b", d_vec(), 5'b00001);
    end
    tick();
    tests_run++;
    if (e_vec() !== 8'h00) begin
      tests_failed++;
      $display("FAIL bne_off_e: got %h expected %h", e_vec(), 8'h00);
    end
`endif
  endtask

  task automatic test_reset_mid();
    drive(OP_ADDI, 6'd0, 1'b0, 1'b0);
    tick();
    tick();
    tests_run++;
    if ({e_vec(), bus.regWriteM} !== {5'b10010, 3'b010, 1'b1}) begin
      tests_failed++;
      $display("FAIL addi_inflight: got %h expected %h", {e_vec(), bus.regWriteM},
               {5'b10010, 3'b010, 1'b1});
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if ({e_vec(), m_vec(), w_vec()} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_all: got %h expected %h", {e_vec(), m_vec(), w_vec()}, 13'd0);
    end
    rst = 1'b0;
    drive(OP_BAD, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({bus.regWriteM, bus.regWriteW} !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_mid_drain[%0d]: got %b expected %b", i,
                 {bus.regWriteM, bus.regWriteW}, 2'b00);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.opCode   = OP_BAD;
    bus.func     = 6'd0;
    bus.equalD   = 1'b0;
    bus.flushE   = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
